wb_regfile: RTL and testbench

Write-back stage and general register file for the five-stage MIPS pipeline. Consumes the MEM/WB pipeline outputs (WB_*), selects the write-back data and destination register, and performs the register write on the clock edge. Provides two combinational read ports to the ID stage with same-cycle write-through bypass, so the ID stage never sees a stale value for a register being written in WB.

---
 rtl/wb_regfile_if.sv | 30 +++
 rtl/wb_regfile.sv | 66 ++++++
 tb/tb_wb_regfile.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/wb_regfile_if.sv
// MEM/WB-to-register-file bus: write-back controls and data in, ID read ports
// and the selected write-back result out.
interface wb_regfile_if;
    logic        WB_RegWr;
    logic [1:0]  WB_RegDst;
    logic [1:0]  WB_MemtoReg;
    logic [4:0]  WB_WrReg;
    logic [4:0]  WB_rd;
    logic [31:0] WB_inA;
    logic [31:0] WB_inB;
    logic [31:0] WB_PC;
    logic [4:0]  ID_rs;
    logic [4:0]  ID_rt;
    logic [31:0] ID_dataA;
    logic [31:0] ID_dataB;
    logic [31:0] WB_wdata;
    logic [4:0]  WB_waddr;
    logic        WB_wen;

    modport master (
        output WB_RegWr, WB_RegDst, WB_MemtoReg, WB_WrReg, WB_rd,
               WB_inA, WB_inB, WB_PC, ID_rs, ID_rt,
        input  ID_dataA, ID_dataB, WB_wdata, WB_waddr, WB_wen
    );
    modport slave (
        input  WB_RegWr, WB_RegDst, WB_MemtoReg, WB_WrReg, WB_rd,
               WB_inA, WB_inB, WB_PC, ID_rs, ID_rt,
        output ID_dataA, ID_dataB, WB_wdata, WB_waddr, WB_wen
    );
endinterface

// File: rtl/wb_regfile.sv
// Write-back stage plus 31x32 MIPS register file ($0 hardwired to zero) with
// two combinational read ports that bypass the in-flight WB write.
module wb_regfile (
    input  logic         clk,
    input  logic         reset,
    wb_regfile_if.slave  bus
);
    localparam int NUM_RD = 2;

    logic [31:0] regs [1:31];
    logic [31:0] wdata;
    logic [4:0]  waddr;
    logic        wen;

    always_comb begin
        waddr = bus.WB_WrReg;
        case (bus.WB_RegDst)
            2'b00: waddr = bus.WB_WrReg;
            2'b01: waddr = bus.WB_rd;
            2'b10: waddr = 5'd31;
            2'b11: waddr = 5'd26;
        endcase
    end

    // PC+4 wraps naturally at 32 bits.
    always_comb begin
        wdata = bus.WB_inA;
        case (bus.WB_MemtoReg)
            2'b00: wdata = bus.WB_inA;
            2'b01: wdata = bus.WB_inB;
            2'b10: wdata = bus.WB_PC + 32'd4;
            2'b11: wdata = bus.WB_inA;
        endcase
    end

    assign wen = bus.WB_RegWr && (waddr != 5'd0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 1; i < 32; i++) regs[i] <= '0;
        end else if (wen) begin
            regs[waddr] <= wdata;
        end
    end

    logic [NUM_RD-1:0][4:0] rd_addr;
    assign rd_addr = {bus.ID_rt, bus.ID_rs};

    for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
        logic [31:0] d;
        always_comb begin
            if (rd_addr[p] == 5'd0)
                d = '0;
            else if (wen && (waddr == rd_addr[p]))
                d = wdata;
            else
                d = regs[rd_addr[p]];
        end
    end

    assign bus.ID_dataA = g_rd[0].d;
    assign bus.ID_dataB = g_rd[1].d;
    assign bus.WB_wdata = wdata;
    assign bus.WB_waddr = waddr;
    assign bus.WB_wen   = wen;
endmodule

// File: tb/tb_wb_regfile.sv
// Directed plus randomized bench for wb_regfile against an array-based model.
module tb_wb_regfile;
    logic clk = 1'b0;
    logic reset;
    wb_regfile_if bus();

    wb_regfile dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    int          ncmp = 0;
    int          nfail = 0;
    logic [31:0] model [32];

    function automatic logic [4:0] m_waddr();
        case (bus.WB_RegDst)
            2'd0: return bus.WB_WrReg;
            2'd1: return bus.WB_rd;
            2'd2: return 5'd31;
            default: return 5'd26;
        endcase
    endfunction

    function automatic logic [31:0] m_wdata();
        if (bus.WB_MemtoReg == 2'd1) return bus.WB_inB;
        if (bus.WB_MemtoReg == 2'd2) return 32'(64'(bus.WB_PC) + 64'd4);
        return bus.WB_inA;
    endfunction

    function automatic logic m_wen();
        return bus.WB_RegWr && (m_waddr() != 0);
    endfunction

    function automatic logic [31:0] m_read(input logic [4:0] a);
        if (a == 0) return 32'h0;
        if (m_wen() && m_waddr() == a) return m_wdata();
        return model[a];
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        #1;
        check({tag, ".wdata"}, bus.WB_wdata, m_wdata());
        check({tag, ".waddr"}, 32'(bus.WB_waddr), 32'(m_waddr()));
        check({tag, ".wen"}, 32'(bus.WB_wen), 32'(m_wen()));
        check({tag, ".dataA"}, bus.ID_dataA, m_read(bus.ID_rs));
        check({tag, ".dataB"}, bus.ID_dataB, m_read(bus.ID_rt));
    endtask

    task automatic drive(input logic wr, input logic [1:0] dst, input logic [1:0] mtr,
                         input logic [4:0] wrreg, input logic [4:0] rd,
                         input logic [31:0] ina, input logic [31:0] inb, input logic [31:0] pc);
        bus.WB_RegWr = wr; bus.WB_RegDst = dst; bus.WB_MemtoReg = mtr;
        bus.WB_WrReg = wrreg; bus.WB_rd = rd;
        bus.WB_inA = ina; bus.WB_inB = inb; bus.WB_PC = pc;
    endtask

    task automatic rd_ports(input logic [4:0] rs, input logic [4:0] rt);
        bus.ID_rs = rs; bus.ID_rt = rt;
    endtask

    // Advance one rising edge (model commits the write) and return at negedge.
    task automatic step();
        logic        w;
        logic [4:0]  a;
        logic [31:0] d;
        w = m_wen(); a = m_waddr(); d = m_wdata();
        @(posedge clk);
        if (!reset && w) model[a] = d;
        @(negedge clk);
    endtask

    task automatic idle();
        drive(1'b0, 2'd0, 2'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0);
    endtask

    initial begin
        for (int i = 0; i < 32; i++) model[i] = 32'h0;
        reset = 1'b1;
        idle();
        rd_ports(5'd0, 5'd0);
        repeat (2) @(negedge clk);

        // Reset state: every address reads zero on both ports.
        for (int i = 0; i < 32; i++) begin
            rd_ports(5'(i), 5'(31 - i));
            #1;
            check("rst.dataA", bus.ID_dataA, 32'h0);
            check("rst.dataB", bus.ID_dataB, 32'h0);
        end
        check("rst.wen", 32'(bus.WB_wen), 32'h0);
        check("rst.wdata", bus.WB_wdata, 32'h0);
        check("rst.waddr", 32'(bus.WB_waddr), 32'h0);
        reset = 1'b0;
        @(negedge clk);

        // rd write, visible through the array next cycle.
        drive(1'b1, 2'd1, 2'd0, 5'd9, 5'd5, 32'h12345678, 32'h0, 32'h0);
        rd_ports(5'd1, 5'd2);
        check_all("wr_rd");
        step();
        idle(); rd_ports(5'd5, 5'd0);
        #1;
        check("rd5.dataA", bus.ID_dataA, 32'h12345678);

        // Same-cycle bypass on both ports.
        drive(1'b1, 2'd0, 2'd1, 5'd7, 5'd3, 32'h0, 32'hDEADBEEF, 32'h0);
        rd_ports(5'd7, 5'd7);
        #1;
        check("byp.dataA", bus.ID_dataA, 32'hDEADBEEF);
        check("byp.dataB", bus.ID_dataB, 32'hDEADBEEF);
        check("byp.wen", 32'(bus.WB_wen), 32'h1);
        step();

        // Write to $0 is dropped.
        drive(1'b1, 2'd1, 2'd0, 5'd4, 5'd0, 32'hFFFFFFFF, 32'h0, 32'h0);
        rd_ports(5'd0, 5'd0);
        #1;
        check("r0.wen", 32'(bus.WB_wen), 32'h0);
        check("r0.dataA", bus.ID_dataA, 32'h0);
        step();
        idle();
        #1;
        check("r0.after", bus.ID_dataA, 32'h0);

        // Link write and PC+4 wraparound.
        drive(1'b1, 2'd2, 2'd2, 5'd1, 5'd1, 32'h0, 32'h0, 32'h00400010);
        rd_ports(5'd5, 5'd9);
        #1;
        check("link.waddr", 32'(bus.WB_waddr), 32'd31);
        check("link.wdata", bus.WB_wdata, 32'h00400014);
        step();
        idle(); rd_ports(5'd0, 5'd31);
        #1;
        check("link.rd31", bus.ID_dataB, 32'h00400014);
        drive(1'b1, 2'd3, 2'd2, 5'd1, 5'd1, 32'h0, 32'h0, 32'hFFFFFFFC);
        #1;
        check("wrap.wdata", bus.WB_wdata, 32'h0);
        check("wrap.waddr", 32'(bus.WB_waddr), 32'd26);
        step();

        // Randomized traffic against the model.
        for (int n = 0; n < 400; n++) begin
            drive(1'($urandom_range(0, 3) != 0), 2'($urandom), 2'($urandom),
                  5'($urandom), 5'($urandom), $urandom, $urandom, $urandom);
            rd_ports(5'($urandom), 5'($urandom));
            check_all("rand");
            step();
        end

        // Async reset between edges clears the array immediately.
        drive(1'b1, 2'd1, 2'd0, 5'd0, 5'd3, 32'hA5A5A5A5, 32'h0, 32'h0);
        rd_ports(5'd3, 5'd3);
        step();
        idle(); rd_ports(5'd3, 5'd31);
        #1;
        check("pre_rst.r3", bus.ID_dataA, 32'hA5A5A5A5);
        #2;
        reset = 1'b1;
        for (int i = 0; i < 32; i++) model[i] = 32'h0;
        #1;
        check("async_rst.r3", bus.ID_dataA, 32'h0);
        check("async_rst.r31", bus.ID_dataB, 32'h0);
        @(negedge clk);
        drive(1'b1, 2'd1, 2'd0, 5'd0, 5'd3, 32'h5A5A5A5A, 32'h0, 32'h0);
        rd_ports(5'd4, 5'd3);
        #1;
        check("rst_hi.byp", bus.ID_dataB, 32'h5A5A5A5A);
        check("rst_hi.r4", bus.ID_dataA, 32'h0);
        step();
        reset = 1'b0;
        idle(); rd_ports(5'd3, 5'd0);
        #1;
        check("rst_wr_drop", bus.ID_dataA, 32'h0);
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
